swap_ctrl: RTL
==============

SWAP_CTRL -- requirements
Module: swap_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 7, meaning register-file address width (2^ADDR_WIDTH locations).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning register-file word width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  swap request, sampled only in IDLE.
REQ-006 The block SHALL have ports addr_a, addr_b  input  ADDR_WIDTH  the two locations to swap.
REQ-007 The block SHALL have port host_we  input  1  host write enable.
REQ-008 The block SHALL have port host_addr_w  input  ADDR_WIDTH  host write address.
REQ-009 The block SHALL have port host_data_w  input  DATA_WIDTH  host write data.
REQ-010 The block SHALL have port host_addr_r  input  ADDR_WIDTH  host read address.
REQ-011 The block SHALL have port host_data_r  output  DATA_WIDTH  host read data, combinationally equal to rf_data_r.
REQ-012 The block SHALL have port host_ready  output  1  high when the host owns the register file (IDLE only).
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port done  output  1  single-cycle completion pulse.
REQ-015 The block SHALL have ports rf_we (1), rf_addr_w (ADDR_WIDTH), rf_data_w (DATA_WIDTH), rf_addr_r (ADDR_WIDTH)  output  driving the register file's synchronous-write/asynchronous-read ports.
REQ-016 The block SHALL have port rf_data_r  input  DATA_WIDTH  register-file asynchronous read data.

Function
REQ-017 The FSM SHALL have states IDLE, RD_A, CP_B, WR_T, DONE, held in a registered state variable.
REQ-018 In IDLE, rf_we/rf_addr_w/rf_data_w/rf_addr_r SHALL equal host_we/host_addr_w/host_data_w/host_addr_r combinationally, and host_ready SHALL be 1.
REQ-019 In IDLE with start=1 at a rising edge, addr_a and addr_b SHALL be captured into a_q and b_q; next state RD_A if addr_a!=addr_b, else DONE.
REQ-020 A host write presented in the same cycle start is accepted SHALL still be performed (ports are muxed by current state, IDLE).
REQ-021 In RD_A: rf_addr_r=a_q, rf_we=0; tmp SHALL load rf_data_r at the edge; next CP_B.
REQ-022 In CP_B: rf_addr_r=b_q, rf_we=1, rf_addr_w=a_q, rf_data_w=rf_data_r; next WR_T.
REQ-023 In WR_T: rf_we=1, rf_addr_w=b_q, rf_data_w=tmp, rf_addr_r=b_q; next DONE.
REQ-024 In DONE: rf_we=0, done=1, busy=1; next IDLE unconditionally.
REQ-025 Latency: start sampled at edge k SHALL give done high during cycle k+4 (a!=b) or cycle k+1 (a==b), and host_ready high again from cycle k+5 or k+2.
REQ-026 The a==b case SHALL issue zero register-file writes.
REQ-027 start while not IDLE SHALL be ignored and not queued; changes to addr_a/addr_b while busy SHALL have no effect.
REQ-028 host_we while host_ready=0 SHALL be dropped (never forwarded to rf_we); the host must retry.
REQ-029 A full swap SHALL perform exactly two writes (a then b) and leave all other locations unchanged.

Reset
REQ-030 While reset_n=0: state=IDLE, a_q=b_q=tmp=0, busy=0, done=0, and rf_we SHALL be forced to 0 irrespective of host_we.
REQ-031 Reset asserted mid-swap SHALL abort immediately with no further writes; memory may be left with location a overwritten (no restore) and start is accepted from the first edge after release.

Verification
REQ-032 Host preload mem[3]=0x11, mem[9]=0x22; start with a=3,b=9 -> done in cycle k+4, writes mem[3]<=0x22 then mem[9]<=0x11, host reads confirm.
REQ-033 start with a=b=5 (mem[5]=0xA5) -> done in cycle k+1, rf_we never asserted, mem[5]=0xA5.
REQ-034 Second start and host_we (addr 0, 0xFF) pulsed during CP_B -> both ignored, mem[0] unchanged, exactly one done pulse.
REQ-035 Back-to-back: start held high continuously with a=0,b=127 -> swaps every 5 cycles, data returns to original after two swaps, address wrap extremes correct.
REQ-036 reset_n low during WR_T -> busy=0, done=0, rf_we=0 immediately; mem[b] not written; new swap after release completes normally.
REQ-037 host_we=1 with reset_n=0 -> no write reaches rf_we.

Source files
------------

// File: rtl/swap_ctrl.sv
// swap_ctrl: exchanges the contents of two register-file locations through a
// single write port and a single asynchronous read port, sharing them with a host.
module swap_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr_w,
  input  logic [DATA_WIDTH-1:0] host_data_w,
  input  logic [ADDR_WIDTH-1:0] host_addr_r,
  output logic [DATA_WIDTH-1:0] host_data_r,
  output logic                  host_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr_w,
  output logic [DATA_WIDTH-1:0] rf_data_w,
  output logic [ADDR_WIDTH-1:0] rf_addr_r,
  input  logic [DATA_WIDTH-1:0] rf_data_r
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    CP_B = 3'd2,
    WR_T = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   a_q, a_d;
  logic [ADDR_WIDTH-1:0]   b_q, b_d;
  logic [DATA_WIDTH-1:0]   tmp_q, tmp_d;

  assign host_data_r = rf_data_r;

  // State and swap operand registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= {ADDR_WIDTH{1'b0}};
      b_q     <= {ADDR_WIDTH{1'b0}};
      tmp_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tmp_q   <= tmp_d;
    end
  end

  // Next-state logic and register-file port muxing.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    tmp_d      = tmp_q;
    rf_we      = 1'b0;
    rf_addr_w  = host_addr_w;
    rf_data_w  = host_data_w;
    rf_addr_r  = host_addr_r;
    host_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        // reset_n gating keeps host writes off the file while reset is held
        rf_we      = host_we & reset_n;
        host_ready = 1'b1;
        busy       = 1'b0;
        if (start) begin
          a_d = addr_a;
          b_d = addr_b;
          if (addr_a != addr_b) begin
            state_d = RD_A;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_A: begin
        rf_addr_r = a_q;
        tmp_d     = rf_data_r;
        state_d   = CP_B;
      end
      CP_B: begin
        rf_addr_r = b_q;
        rf_we     = 1'b1;
        rf_addr_w = a_q;
        rf_data_w = rf_data_r;
        state_d   = WR_T;
      end
      WR_T: begin
        rf_we     = 1'b1;
        rf_addr_w = b_q;
        rf_data_w = tmp_q;
        rf_addr_r = b_q;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
